// File: rtl/darkmem_pkg.sv
// darkmem_pkg
//   Shared types and constants for the darkmemctl memory-side slave.
//   - mem_state_t : controller FSM states
//   - IO_SEL_BIT  : address bit selecting the IO region over RAM
//   - CNT_W       : width of the service-latency down-counter
package darkmem_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        BUSY      = 2'd1,
        RESP      = 2'd2,
        WAIT_DROP = 2'd3
    } mem_state_t;

    localparam int IO_SEL_BIT = 31;
    localparam int CNT_W      = 8;

endpackage

// File: rtl/darkmemctl_ram.sv
// darkmemctl_ram
//   Synchronous byte-enable word RAM with read-before-write. Word 0 lives in
//   its own asynchronously reset register so the board LEDs come up dark.
// Ports:
//   clk    in   clock, rising edge
//   rstn   in   asynchronous active-low reset (word 0 and rdata only)
//   we     in   write enable
//   be     in   byte lane enables, bit n covers wdata[8n+7:8n]
//   idx    in   word index for both read and write
//   wdata  in   write data
//   rdata  out  registered read data: the word at idx before this edge's write
//   word0  out  current contents of word 0
module darkmemctl_ram
    import darkmem_pkg::*;
#(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  we,
    input  logic [3:0]            be,
    input  logic [DEPTH_LOG2-1:0] idx,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata,
    output logic [31:0]           word0
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    // Entry 0 of the array shadows word0 on writes but is never read back.
    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            word0 <= '0;
            rdata <= '0;
        end else begin
            // Non-blocking read of the old value gives read-before-write.
            rdata <= (idx == '0) ? word0 : mem[idx];
            if (we && (idx == '0)) begin
                for (int b = 0; b < 4; b++) begin
                    if (be[b]) word0[8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/darkmemctl.sv
// darkmemctl
//   Memory-side slave behind the darkpablomem scheduler. Accepts one request
//   at a time on the PAB_* channel, waits LATENCY cycles, then commits the
//   read/write and pulses MEM_VALID for one cycle. ADDR[31]=0 targets the
//   RAM (index ADDR[DEPTH_LOG2+1:2], upper bits alias), ADDR[31]=1 is the IO
//   region (writes dropped, reads return the LED value).
// Handshake: a request is accepted on a rising edge where PAB_VALID and
//   MEM_READY are both high; MEM_READY stays low until the request has
//   completed and PAB_VALID has been seen low, so a held request is serviced
//   only once. MEM_VALID is high for exactly one cycle per accepted request.
// Ports:
//   XCLK       in   clock
//   XRES       in   asynchronous active-low reset
//   PAB_VALID  in   request present
//   PAB_RD     in   read request
//   PAB_WR     in   write request
//   PAB_ADDR   in   byte address
//   PAB_DATA   in   write data
//   PAB_BE     in   byte enables
//   MEM_READY  out  idle, can accept
//   MEM_VALID  out  one-cycle completion pulse
//   MEM_DATA   out  read data, held until the next read completion
//   LED        out  RAM word 0 bits 3:0
module darkmemctl
    import darkmem_pkg::*;
#(
    parameter int DEPTH_LOG2 = 4,
    parameter int LATENCY    = 15
) (
    input  logic        XCLK,
    input  logic        XRES,
    input  logic        PAB_VALID,
    input  logic        PAB_RD,
    input  logic        PAB_WR,
    input  logic [31:0] PAB_ADDR,
    input  logic [31:0] PAB_DATA,
    input  logic [3:0]  PAB_BE,
    output logic        MEM_READY,
    output logic        MEM_VALID,
    output logic [31:0] MEM_DATA,
    output logic [3:0]  LED
);

    localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(LATENCY - 1);

    mem_state_t state, state_nxt;

    logic [CNT_W-1:0]      cnt;
    logic                  rd_q, wr_q, io_q;
    logic [DEPTH_LOG2-1:0] idx_q;
    logic [31:0]           data_q;
    logic [3:0]            be_q;

    logic                  accept, commit;
    logic [DEPTH_LOG2-1:0] req_idx, ram_idx;
    logic [31:0]           ram_rdata, word0;

    // Address bits that the decode deliberately ignores.
    logic unused_bits;
    assign unused_bits = ^{PAB_ADDR[30:DEPTH_LOG2+2], PAB_ADDR[1:0], word0[31:4]};

    assign req_idx = PAB_ADDR[DEPTH_LOG2+1:2];
    assign accept  = (state == IDLE) && PAB_VALID;
    // Edge that enters RESP: the captured request commits here.
    assign commit  = (state == BUSY) && (cnt == '0);

    // While idle the RAM read port tracks the incoming address so its
    // registered output already holds the target word one edge after
    // acceptance; afterwards the captured index is held, and nothing else
    // writes the RAM until commit, so rdata is the pre-write value.
    assign ram_idx = (state == IDLE) ? req_idx : idx_q;

    always_ff @(posedge XCLK or negedge XRES) begin
        if (!XRES) state <= IDLE;
        else       state <= state_nxt;
    end

    // A LATENCY of 1 loads the counter with 0, so BUSY lasts a single cycle
    // and RESP is entered on the edge after acceptance.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (PAB_VALID) state_nxt = BUSY;
            BUSY:      if (cnt == '0) state_nxt = RESP;
            RESP:      state_nxt = PAB_VALID ? WAIT_DROP : IDLE;
            WAIT_DROP: if (!PAB_VALID) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge XCLK or negedge XRES) begin
        if (!XRES) begin
            cnt      <= '0;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            io_q     <= 1'b0;
            idx_q    <= '0;
            data_q   <= '0;
            be_q     <= '0;
            MEM_DATA <= '0;
        end else begin
            if (accept) begin
                cnt    <= LAT_M1;
                rd_q   <= PAB_RD;
                wr_q   <= PAB_WR;
                io_q   <= PAB_ADDR[IO_SEL_BIT];
                idx_q  <= req_idx;
                data_q <= PAB_DATA;
                be_q   <= PAB_BE;
            end else if ((state == BUSY) && (cnt != '0)) begin
                cnt <= cnt - 1'b1;
            end
            if (commit && rd_q) begin
                MEM_DATA <= io_q ? {28'b0, word0[3:0]} : ram_rdata;
            end
        end
    end

    darkmemctl_ram #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_ram (
        .clk   (XCLK),
        .rstn  (XRES),
        .we    (commit && wr_q && !io_q),
        .be    (be_q),
        .idx   (ram_idx),
        .wdata (data_q),
        .rdata (ram_rdata),
        .word0 (word0)
    );

    assign MEM_READY = (state == IDLE);
    assign MEM_VALID = (state == RESP);
    assign LED       = word0[3:0];

endmodule

// File: tb/tb_darkmemctl.sv
// tb_darkmemctl
//   Two controllers (LATENCY 15 and LATENCY 1) share one request bus and are
//   compared against a word-array model of the memory and IO map.
module tb_darkmemctl;

    localparam int DEPTH_LOG2 = 4;
    localparam int NW         = 1 << DEPTH_LOG2;
    localparam int LAT0       = 15;
    localparam int LAT1       = 1;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        p_valid, p_rd, p_wr;
    logic [31:0] p_addr, p_data;
    logic [3:0]  p_be;
    logic [1:0]  mem_ready, mem_valid;
    logic [31:0] mem_data [2];
    logic [3:0]  led [2];

    darkmemctl #(.DEPTH_LOG2(DEPTH_LOG2), .LATENCY(LAT0)) u_dut (
        .XCLK(clk), .XRES(rst_n), .PAB_VALID(p_valid), .PAB_RD(p_rd), .PAB_WR(p_wr),
        .PAB_ADDR(p_addr), .PAB_DATA(p_data), .PAB_BE(p_be),
        .MEM_READY(mem_ready[0]), .MEM_VALID(mem_valid[0]), .MEM_DATA(mem_data[0]), .LED(led[0])
    );

    darkmemctl #(.DEPTH_LOG2(DEPTH_LOG2), .LATENCY(LAT1)) u_dut_l1 (
        .XCLK(clk), .XRES(rst_n), .PAB_VALID(p_valid), .PAB_RD(p_rd), .PAB_WR(p_wr),
        .PAB_ADDR(p_addr), .PAB_DATA(p_data), .PAB_BE(p_be),
        .MEM_READY(mem_ready[1]), .MEM_VALID(mem_valid[1]), .MEM_DATA(mem_data[1]), .LED(led[1])
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    logic [31:0] exp_q [$];
    logic [31:0] mem_m [NW];
    logic [31:0] last_data_m = '0;

    function automatic int lat_of(input int i);
        return (i == 0) ? LAT0 : LAT1;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference: reads see the old word, then the write lands lane by lane.
    task automatic model_apply(input logic rd, input logic wr, input logic [31:0] addr,
                               input logic [31:0] data, input logic [3:0] be);
        logic [31:0] exp;
        int w;
        w = int'(addr[DEPTH_LOG2+1:2]);
        if (rd) exp = addr[31] ? {28'b0, mem_m[0][3:0]} : mem_m[w];
        else    exp = last_data_m;
        if (wr && !addr[31]) begin
            for (int b = 0; b < 4; b++)
                if (be[b]) mem_m[w][8*b +: 8] = data[8*b +: 8];
        end
        last_data_m = exp;
        exp_q.push_back(exp);
    endtask

    // ---------------- driver ----------------
    // Issue one request, hold PAB_VALID for 'hold' accepting edges, and watch
    // both controllers until they are idle again.
    task automatic do_req(input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [31:0] data, input logic [3:0] be, input int hold);
        int pulses [2];
        int pulse_k [2];
        int ready_bad [2];
        int idle_k, last_k, waitc;
        logic [31:0] exp;
        waitc = 0;
        while (!(mem_ready[0] && mem_ready[1]) && waitc < 200) begin
            @(negedge clk);
            waitc++;
        end
        if (waitc >= 200) check("idle_timeout", 32'(mem_ready), 32'h3);
        model_apply(rd, wr, addr, data, be);
        p_valid = 1'b1; p_rd = rd; p_wr = wr; p_addr = addr; p_data = data; p_be = be;
        for (int i = 0; i < 2; i++) begin
            pulses[i] = 0; pulse_k[i] = -1; ready_bad[i] = 0;
        end
        last_k = ((LAT0 + 1 > hold) ? LAT0 + 1 : hold) + 2;
        @(posedge clk);  // t0: acceptance edge
        for (int k = 0; k <= last_k; k++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (mem_valid[i]) begin
                    pulses[i]++;
                    if (pulse_k[i] < 0) pulse_k[i] = k;
                end
                idle_k = (lat_of(i) + 1 > hold) ? lat_of(i) + 1 : hold;
                if (mem_ready[i] !== (k >= idle_k)) ready_bad[i]++;
            end
            // Captured values only: scramble the bus once the request is in.
            p_rd = 1'($urandom); p_wr = 1'($urandom); p_addr = $urandom;
            p_data = $urandom; p_be = 4'($urandom);
            if (k + 1 >= hold) p_valid = 1'b0;
        end
        exp = exp_q.pop_front();
        for (int i = 0; i < 2; i++) begin
            check($sformatf("pulse_count[%0d]", i), 32'(pulses[i]), 32'd1);
            check($sformatf("pulse_cycle[%0d]", i), 32'(pulse_k[i]), 32'(lat_of(i)));
            check($sformatf("ready_profile[%0d]", i), 32'(ready_bad[i]), 32'd0);
            check($sformatf("mem_data[%0d]", i), mem_data[i], exp);
            check($sformatf("led[%0d]", i), 32'(led[i]), 32'(mem_m[0][3:0]));
        end
    endtask

    task automatic check_reset_state(input string tag);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("%s_ready[%0d]", tag, i), 32'(mem_ready[i]), 32'd1);
            check($sformatf("%s_valid[%0d]", tag, i), 32'(mem_valid[i]), 32'd0);
            check($sformatf("%s_data[%0d]", tag, i), mem_data[i], 32'd0);
            check($sformatf("%s_led[%0d]", tag, i), 32'(led[i]), 32'd0);
        end
    endtask

    // Write 0x5 to word 0, then pull reset after edge t0+7.
    task automatic do_reset_mid();
        int pulses0;
        pulses0 = 0;
        p_valid = 1'b1; p_rd = 1'b0; p_wr = 1'b1; p_addr = 32'h0; p_data = 32'h5; p_be = 4'hF;
        @(posedge clk);  // t0
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            if (mem_valid[0]) pulses0++;
            p_valid = 1'b0;
        end
        @(posedge clk);  // t0+7
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_state("mid_reset");
        mem_m[0] = '0;
        last_data_m = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (mem_valid[0]) pulses0++;
        end
        check("abort_no_pulse", 32'(pulses0), 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] a;
        p_valid = 1'b0; p_rd = 1'b0; p_wr = 1'b0;
        p_addr = '0; p_data = '0; p_be = '0;
        for (int w = 0; w < NW; w++) mem_m[w] = '0;
        repeat (3) @(negedge clk);
        check_reset_state("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Reset then write: LED shows 1010.
        do_req(1'b0, 1'b1, 32'h0, 32'h0000000A, 4'hF, 1);
        check("led_after_write", 32'(led[0]), 32'hA);

        // Byte-lane merge.
        do_req(1'b0, 1'b1, 32'h8, 32'h11223344, 4'hF, 1);
        do_req(1'b0, 1'b1, 32'h8, 32'hAABBCCDD, 4'h5, 1);
        do_req(1'b1, 1'b0, 32'h8, 32'h0, 4'h0, 1);
        check("lane_merge", mem_data[0], 32'h11BB33DD);

        // Aliasing and IO region.
        do_req(1'b1, 1'b0, 32'h40, 32'h0, 4'h0, 1);
        check("alias_word0", mem_data[0], 32'h0000000A);
        do_req(1'b0, 1'b1, 32'h80000000, 32'hF, 4'hF, 1);
        do_req(1'b1, 1'b0, 32'h0, 32'h0, 4'h0, 1);
        check("io_write_dropped", mem_data[0], 32'h0000000A);
        do_req(1'b1, 1'b0, 32'h80000000, 32'h0, 4'h0, 1);
        check("io_read", mem_data[0], 32'h0000000A);

        // BE==0 write and a no-op request.
        do_req(1'b0, 1'b1, 32'h8, 32'hFFFFFFFF, 4'h0, 1);
        do_req(1'b0, 1'b0, 32'h8, 32'hFFFFFFFF, 4'hF, 3);

        // Held VALID across completion.
        do_req(1'b1, 1'b0, 32'h8, 32'h0, 4'h0, 40);

        // Reset mid-transaction; word 0 must read back as zero.
        do_reset_mid();
        do_req(1'b1, 1'b0, 32'h0, 32'h0, 4'h0, 1);

        // Read-before-write with RD and WR together.
        do_req(1'b0, 1'b1, 32'h4, 32'h00001234, 4'hF, 1);
        do_req(1'b1, 1'b1, 32'h4, 32'h00009999, 4'hF, 1);
        check("rmw_old_data", mem_data[1], 32'h00001234);
        do_req(1'b1, 1'b0, 32'h4, 32'h0, 4'h0, 1);
        check("rmw_new_data", mem_data[1], 32'h00009999);

        // Fill every word, then random traffic.
        for (int w = 0; w < NW; w++)
            do_req(1'b0, 1'b1, 32'(w) << 2, $urandom, 4'hF, 1);
        for (int n = 0; n < 50; n++) begin
            a = $urandom;
            if ($urandom_range(0, 3) != 0) a[31] = 1'b0;
            do_req(1'($urandom), 1'($urandom), a, $urandom, 4'($urandom),
                   ($urandom_range(0, 2) == 0) ? $urandom_range(2, 20) : 1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
